// File: rtl/zigbee_uart_rx.sv
// -----------------------------------------------------------------------------
// zigbee_uart_rx
//   UART receiver for the Zigbee serial link feeding the car control core.
//   Deserialises LSB-first frames (8N1 by default) and presents each good byte
//   on receiveData. It then raises a width-controlled strobe whose rising edge
//   the control core uses as its trigger.
//
//   Optional build macro: ZIGBEE_RX_PARITY_EN
//     defined   -> frames are 8E1. A parity mismatch with a good stop bit is
//                  rejected with frame_err and the receiver returns to IDLE.
//     undefined -> frames are 8N1. No parity logic is built.
//
// Parameters
//   CLK_HZ        system clock frequency in Hz
//   BAUD          line baud rate
//   PULSE_CYCLES  receive strobe width in clk_50M cycles (1 .. DIV-4)
//
// Ports
//   clk_50M      in   system clock; all logic runs on its rising edge
//   rst          in   synchronous active-high reset
//   rxd          in   asynchronous serial line, idle high
//   receiveData  out  [7:0] last correctly framed byte
//   receive      out  new-byte strobe, high PULSE_CYCLES cycles per byte
//   frame_err    out  one-cycle pulse on a rejected frame
//   busy         out  high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module zigbee_uart_rx #(
  parameter int CLK_HZ       = 50000000,
  parameter int BAUD         = 9600,
  parameter int PULSE_CYCLES = 16
) (
  input  logic       clk_50M,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] receiveData,
  output logic       receive,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef ZIGBEE_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAITHI
  } state_t;

  state_t           state, state_nxt;
  logic             rxd_m, rxd_s;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic [CNT_W-1:0] strobe_cnt;
  logic             accept_q;
  logic             rearm_q;

  // FSM control decoded combinationally, applied in the datapath below
  logic cnt_clr;
  logic shift_en;
  logic accept;
  logic reject;
  logic half_hit;
  logic bit_hit;
  logic parity_ok;

`ifdef ZIGBEE_RX_PARITY_EN
  logic par_en;
  logic par_bit;
`endif

  assign half_hit = (baud_cnt == HALF_LAST);
  assign bit_hit  = (baud_cnt == DIV_LAST);
  assign busy     = (state != IDLE);

`ifdef ZIGBEE_RX_PARITY_EN
  // Even parity: data bits and parity bit together must XOR to zero
  assign parity_ok = ~(^{shreg, par_bit});
`else
  assign parity_ok = 1'b1;
`endif

  // Two-flop synchroniser; the FSM looks only at rxd_s
  always_ff @(posedge clk_50M) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  always_ff @(posedge clk_50M) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_nxt = state;
    cnt_clr   = 1'b0;
    shift_en  = 1'b0;
    accept    = 1'b0;
    reject    = 1'b0;
`ifdef ZIGBEE_RX_PARITY_EN
    par_en    = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!rxd_s) state_nxt = START;
      end
      START: begin
        // Re-check the line at mid start bit to reject glitches
        if (half_hit) begin
          cnt_clr   = 1'b1;
          state_nxt = rxd_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_hit) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) begin
`ifdef ZIGBEE_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef ZIGBEE_RX_PARITY_EN
      PARITY: begin
        if (bit_hit) begin
          cnt_clr   = 1'b1;
          par_en    = 1'b1;
          state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_hit) begin
          cnt_clr = 1'b1;
          if (!rxd_s) begin
            // Broken stop bit: wait for the line to idle so a held break
            // is not decoded as a stream of 0x00 bytes
            reject    = 1'b1;
            state_nxt = WAITHI;
          end else if (parity_ok) begin
            accept    = 1'b1;
            state_nxt = IDLE;
          end else begin
            reject    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      WAITHI: begin
        cnt_clr = 1'b1;
        if (rxd_s) state_nxt = IDLE;
      end
      default: begin
        cnt_clr   = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  // Receive datapath
  always_ff @(posedge clk_50M) begin
    // NOTE: only plain registers here, so all of them take a reset value.
    if (rst) begin
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      receiveData <= '0;
      frame_err   <= 1'b0;
      accept_q    <= 1'b0;
    end else begin
      baud_cnt  <= cnt_clr ? '0 : baud_cnt + 1'b1;
      frame_err <= reject;
      accept_q  <= accept;
      if (state == IDLE) bit_cnt <= '0;
      else if (shift_en) bit_cnt <= (bit_cnt == 3'd7) ? 3'd0 : bit_cnt + 3'd1;
      if (shift_en) shreg <= {rxd_s, shreg[7:1]};
      if (accept)   receiveData <= shreg;
    end
  end

`ifdef ZIGBEE_RX_PARITY_EN
  always_ff @(posedge clk_50M) begin
    if (rst)         par_bit <= 1'b0;
    else if (par_en) par_bit <= rxd_s;
  end
`endif

  // Strobe generator. accept_q delays the strobe one cycle behind the data
  // load, so receiveData is settled before the rising edge. A byte accepted
  // while the strobe is still high drops it for one cycle and re-arms it,
  // guaranteeing a fresh rising edge.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      receive    <= 1'b0;
      strobe_cnt <= '0;
      rearm_q    <= 1'b0;
    end else begin
      rearm_q <= 1'b0;
      if (accept_q && receive) begin
        receive <= 1'b0;
        rearm_q <= 1'b1;
      end else if (accept_q || rearm_q) begin
        receive    <= 1'b1;
        strobe_cnt <= PULSE_LAST;
      end else if (receive) begin
        if (strobe_cnt == '0) receive    <= 1'b0;
        else                  strobe_cnt <= strobe_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_zigbee_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_zigbee_uart_rx
//   Self-checking bench for zigbee_uart_rx. A scaled-down bit period keeps the
//   run short while keeping the 16-cycle strobe. The expected stream of
//   accepted bytes and rejected frames comes from a frame-level model. A
//   passive monitor records each strobe (data at and before its rising edge,
//   width), frame_err pulses and any data change while the strobe is high.
// -----------------------------------------------------------------------------
module tb_zigbee_uart_rx;

  localparam int CLK_HZ = 320;
  localparam int BAUD   = 10;
  localparam int PULSE  = 16;
  localparam int DIV    = CLK_HZ / BAUD;

`ifdef ZIGBEE_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk_50M = 1'b0;
  logic       rst     = 1'b1;
  logic       rxd     = 1'b1;
  logic [7:0] receiveData;
  logic       receive;
  logic       frame_err;
  logic       busy;

  always #5 clk_50M = ~clk_50M;

  zigbee_uart_rx #(
    .CLK_HZ      (CLK_HZ),
    .BAUD        (BAUD),
    .PULSE_CYCLES(PULSE)
  ) dut (
    .clk_50M    (clk_50M),
    .rst        (rst),
    .rxd        (rxd),
    .receiveData(receiveData),
    .receive    (receive),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;

  // Monitor state
  logic [7:0] rise_q[$];
  logic [7:0] pre_q[$];
  int         len_q[$];
  int         len       = 0;
  int         err_seen  = 0;
  int         err_long  = 0;
  int         unstable  = 0;
  logic       prev_rcv  = 1'b0;
  logic       prev_err  = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk_50M) begin
    if (receive && !prev_rcv) begin
      rise_q.push_back(receiveData);
      pre_q.push_back(prev_data);
      len <= 1;
    end else if (receive) begin
      len <= len + 1;
      if (receiveData !== prev_data) unstable <= unstable + 1;
    end
    if (!receive && prev_rcv) len_q.push_back(len);
    if (frame_err)              err_seen <= err_seen + 1;
    if (frame_err && prev_err)  err_long <= err_long + 1;
    prev_rcv  <= receive;
    prev_err  <= frame_err;
    prev_data <= receiveData;
  end

  // Frame-level reference model
  logic [7:0] exp_q[$];
  int         exp_err   = 0;
  logic [7:0] last_good = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_50M);
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    wait_cyc(DIV);
  endtask

  // Sends one frame; par_ok=0 flips the even parity bit (parity builds only)
  task automatic tx(input logic [7:0] d, input logic stop_ok, input logic par_ok);
    if (stop_ok && (par_ok || !PAR_EN)) begin
      exp_q.push_back(d);
      last_good = d;
    end else begin
      exp_err++;
    end
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (PAR_EN) send_bit((^d) ^ ~par_ok);
    send_bit(stop_ok);
    rxd = 1'b1;
  endtask

  // Compares everything observed since the last call against the model
  task automatic check_stream(input string tag);
    int n;
    wait_cyc(2 * DIV);
    @(posedge clk_50M);
    check({tag, "_strobe_count"}, rise_q.size(), exp_q.size());
    check({tag, "_width_count"},  len_q.size(),  exp_q.size());
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      if (rise_q.size() > 0) check({tag, "_data_at_rise"}, rise_q.pop_front(), e);
      if (pre_q.size() > 0)  check({tag, "_data_before_rise"}, pre_q.pop_front(), e);
      if (len_q.size() > 0)  check({tag, "_strobe_width"}, len_q.pop_front(), PULSE);
    end
    rise_q.delete();
    pre_q.delete();
    len_q.delete();
    check({tag, "_frame_err_count"}, err_seen, exp_err);
    check({tag, "_frame_err_width"}, err_long, 0);
    check({tag, "_data_stable"},     unstable, 0);
    check({tag, "_receiveData"},     receiveData, last_good);
    check({tag, "_idle"},            busy, 1'b0);
    @(negedge clk_50M);
  endtask

  initial begin
    // Reset values
    rst = 1'b1;
    rxd = 1'b1;
    wait_cyc(3);
    check("reset_receiveData", receiveData, 8'h00);
    check("reset_receive",     receive,     1'b0);
    check("reset_frame_err",   frame_err,   1'b0);
    check("reset_busy",        busy,        1'b0);
    rst = 1'b0;
    wait_cyc(DIV);

    // Single good byte
    tx(8'hA5, 1'b1, 1'b1);
    check_stream("a5");

    // False start shorter than half a bit
    rxd = 1'b0;
    wait_cyc(10);
    check("false_start_busy", busy, 1'b1);
    rxd = 1'b1;
    wait_cyc(3 * DIV);
    check_stream("false_start");

    // Broken stop bit followed by a long break, then a good byte
    tx(8'h3C, 1'b0, 1'b1);
    rxd = 1'b0;
    wait_cyc(20 * DIV);
    check("break_receiveData", receiveData, last_good);
    check("break_busy",        busy,        1'b1);
    check("break_err_count",   err_seen,    exp_err);
    rxd = 1'b1;
    wait_cyc(2 * DIV);
    tx(8'h81, 1'b1, 1'b1);
    check_stream("break");

    // Back-to-back bytes with no idle gap
    tx(8'h41, 1'b1, 1'b1);
    tx(8'hC2, 1'b1, 1'b1);
    check_stream("b2b");

    // Reset in the middle of data bit 4 of 0xFF
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    wait_cyc(DIV / 2);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    check("midreset_receiveData", receiveData, 8'h00);
    check("midreset_receive",     receive,     1'b0);
    check("midreset_frame_err",   frame_err,   1'b0);
    check("midreset_busy",        busy,        1'b0);
    last_good = 8'h00;
    wait_cyc(DIV / 2 + 4 * DIV);
    tx(8'h12, 1'b1, 1'b1);
    check_stream("midreset");

    // Randomised frames: random data, occasional broken stop/parity, random gaps
    for (int k = 0; k < 10; k++) begin
      logic [7:0] d;
      logic       s_ok;
      logic       p_ok;
      d    = 8'($urandom);
      s_ok = ($urandom_range(0, 3) != 0);
      p_ok = ($urandom_range(0, 3) != 0);
      tx(d, s_ok, p_ok);
      if (!s_ok) begin
        rxd = 1'b0;
        wait_cyc($urandom_range(DIV, 3 * DIV));
        rxd = 1'b1;
        wait_cyc(DIV);
      end else begin
        wait_cyc($urandom_range(0, DIV));
      end
    end
    check_stream("random");

`ifdef ZIGBEE_RX_PARITY_EN
    // 0x07 has odd weight: parity bit 1 is correct, parity bit 0 is not
    tx(8'h07, 1'b1, 1'b1);
    tx(8'h07, 1'b1, 1'b0);
    check_stream("parity");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
